// File: rtl/mem_seq.sv
// mem_seq: byte-serial load/store sequencer over an 8-bit fixed-latency RAM port.
// Optional build macro MEM_SEQ_MISALIGN_TRAP_EN adds misalign_o and traps misaligned half/word.
module mem_seq #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              req_i,
    input  logic              is_store_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              wreg_i,
    input  logic [4:0]        waddr_i,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    output logic              misalign_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              wreg_o,
    output logic [4:0]        waddr_o
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t            state, state_n;
    logic [1:0]        idx;
    logic [3:0]        wcnt;
    logic [31:0]       result;
    logic              st_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              wreg_q;
    logic [4:0]        waddr_q;
    logic              mis_q;
    logic              mis_in;
    logic [1:0]        last_idx;
    logic              wait_end;
    logic [7:0]        wbyte;
    logic [31:0]       ext;

`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    assign mis_in = (size_i == 2'd1 && addr_i[0]) ||
                    (size_i == 2'd2 && addr_i[1:0] != 2'b00);
    assign misalign_o = (state == DONE) && mis_q;
`else
    assign mis_in = 1'b0;
`endif

    assign wait_end = (wcnt == 4'(RD_LAT - 1));

    // Index of the final byte and store byte lane for the current index
    always_comb begin
        last_idx = 2'd3;
        wbyte    = wdata_q[7:0];
        unique case (size_q)
            2'd0:    last_idx = 2'd0;
            2'd1:    last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        unique case (idx)
            2'd0: wbyte = wdata_q[7:0];
            2'd1: wbyte = wdata_q[15:8];
            2'd2: wbyte = wdata_q[23:16];
            2'd3: wbyte = wdata_q[31:24];
        endcase
    end

    // Extend the assembled load result to 32 bits
    always_comb begin
        ext = result;
        unique case (size_q)
            2'd0:    ext = {{24{sext_q & result[7]}}, result[7:0]};
            2'd1:    ext = {{16{sext_q & result[15]}}, result[15:0]};
            default: ext = result;
        endcase
    end

    // Next-state and strobe/result outputs
    always_comb begin
        state_n  = state;
        mem_re_o = 1'b0;
        mem_we_o = 1'b0;
        busy_o   = (state != IDLE);
        done_o   = 1'b0;
        rdata_o  = 32'd0;
        wreg_o   = 1'b0;
        waddr_o  = 5'd0;
        unique case (state)
            IDLE: begin
                if (req_i && !stall_i) begin
                    if (size_i == 2'd3 || mis_in) state_n = DONE;
                    else if (is_store_i)          state_n = STORE;
                    else                          state_n = LOAD;
                end
            end
            LOAD: begin
                if (!stall_i) begin
                    mem_re_o = 1'b1;
                    if (wait_end && idx == last_idx) state_n = DONE;
                end
            end
            STORE: begin
                if (!stall_i) begin
                    mem_we_o = 1'b1;
                    if (idx == last_idx) state_n = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                wreg_o  = wreg_q & ~mis_q;
                waddr_o = waddr_q;
                if (!st_q && size_q != 2'd3 && !mis_q) rdata_o = ext;
                if (!stall_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr_o  = (mem_re_o || mem_we_o) ? addr_q + ADDR_W'(idx) : '0;
    assign mem_wdata_o = mem_we_o ? wbyte : 8'd0;

    // State, byte index, wait counter, result and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            wcnt    <= 4'd0;
            result  <= 32'd0;
            st_q    <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wreg_q  <= 1'b0;
            waddr_q <= 5'd0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req_i && !stall_i) begin
                        st_q    <= is_store_i;
                        size_q  <= size_i;
                        sext_q  <= sign_ext_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        wreg_q  <= wreg_i;
                        waddr_q <= waddr_i;
                        mis_q   <= mis_in;
                        idx     <= 2'd0;
                        wcnt    <= 4'd0;
                        result  <= 32'd0;
                    end
                end
                LOAD: begin
                    if (stall_i) begin
                        wcnt <= 4'd0;
                    end else if (wait_end) begin
                        result[{idx, 3'b000} +: 8] <= mem_rdata_i;
                        wcnt <= 4'd0;
                        idx  <= idx + 2'd1;
                    end else begin
                        wcnt <= wcnt + 4'd1;
                    end
                end
                STORE: begin
                    if (!stall_i) idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: randomized scoreboard bench for mem_seq.
// Driver pushes expected writes/completions; a negedge monitor pops and compares.
module tb_mem_seq;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              stall_i;
    logic              req_i;
    logic              is_store_i;
    logic [1:0]        size_i;
    logic              sign_ext_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic              wreg_i;
    logic [4:0]        waddr_i;
    logic              mem_re_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [7:0]        mem_rdata_i;
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    logic              misalign_o;
`endif
    logic              busy_o;
    logic              done_o;
    logic [31:0]       rdata_o;
    logic              wreg_o;
    logic [4:0]        waddr_o;

    mem_seq #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .req_i      (req_i),
        .is_store_i (is_store_i),
        .size_i     (size_i),
        .sign_ext_i (sign_ext_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .wreg_i     (wreg_i),
        .waddr_i    (waddr_i),
        .mem_re_o   (mem_re_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
        .misalign_o (misalign_o),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .wreg_o     (wreg_o),
        .waddr_o    (waddr_o)
    );

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  waddr;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        wreg;
        logic [4:0]  waddr;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   bcnt = 0;

    logic [7:0] ram [0:4095];

    assign mem_rdata_i = ram[mem_addr_o[11:0]];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we_o) ram[mem_addr_o[11:0]] = mem_wdata_o;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: invariant checks plus scoreboard pops
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (stall_i) begin
            chk("stall_re", 32'(mem_re_o), 32'd0);
            chk("stall_we", 32'(mem_we_o), 32'd0);
        end
        if (!mem_re_o && !mem_we_o) begin
            chk("quiet_addr", mem_addr_o, 32'd0);
            chk("quiet_wdata", 32'(mem_wdata_o), 32'd0);
        end
        if (!done_o) begin
            chk("nd_rdata", rdata_o, 32'd0);
            chk("nd_wreg", 32'(wreg_o), 32'd0);
            chk("nd_waddr", 32'(waddr_o), 32'd0);
        end
        if (!busy_o)
            chk("idle_strobes", 32'({mem_re_o, mem_we_o, done_o}), 32'd0);
        if (mem_we_o) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_write: got addr %h expected none",
                         mem_addr_o);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", mem_addr_o, w.addr);
                chk("wr_data", 32'(mem_wdata_o), 32'(w.data));
            end
        end
        if (done_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done_o=1 expected 0");
            end else begin
                e = exp_q[0];
                chk("rdata", rdata_o, e.rdata);
                chk("wreg", 32'(wreg_o), 32'(e.wreg));
                chk("waddr", 32'(waddr_o), 32'(e.waddr));
                if (!stall_i) begin
                    chk("latency", 32'(bcnt), 32'(e.lat));
                    void'(exp_q.pop_front());
                    bcnt = 0;
                end
            end
        end else if (busy_o) begin
            bcnt++;
        end
        if (rst) bcnt = 0;
    end

    task automatic garble();
        req_i      = 1'($urandom_range(0, 1));
        is_store_i = 1'($urandom_range(0, 1));
        size_i     = 2'($urandom_range(0, 3));
        sign_ext_i = 1'($urandom_range(0, 1));
        addr_i     = $urandom;
        wdata_i    = $urandom;
        wreg_i     = 1'($urandom_range(0, 1));
        waddr_i    = 5'($urandom_range(0, 31));
    endtask

    // Issue one access from IDLE; push expectations; drive until it ends
    task automatic run(input txn_t t, input int stall_at, input int stall_len,
                       input int dstall, input int rst_at);
        int          n;
        logic [31:0] raw;
        exp_t        e;
        wr_t         w;
        bit          mis;
        int          ds;
        n   = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
        mis = 1'b0;
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
        mis = (t.size == 2'd1 && t.addr[0]) ||
              (t.size == 2'd2 && t.addr[1:0] != 2'b00);
`endif
        e.wreg  = t.wreg & ~mis;
        e.waddr = t.waddr;
        e.rdata = 32'd0;
        e.lat   = 0;
        if (t.size != 2'd3 && !mis) begin
            if (t.store) begin
                e.lat = n + stall_len;
                for (int k = 0; k < n; k++) begin
                    if (rst_at < 0 || k <= rst_at) begin
                        w.addr = t.addr + 32'(k);
                        w.data = t.wdata[8*k +: 8];
                        wr_q.push_back(w);
                    end
                end
            end else begin
                raw = 32'd0;
                for (int k = 0; k < n; k++)
                    raw[8*k +: 8] = ram[12'(t.addr + 32'(k))];
                e.rdata = (t.sext && raw[8*n-1]) ?
                          raw | ~32'((64'd1 << (8*n)) - 64'd1) : raw;
                e.lat = n * RD_LAT + stall_len +
                        ((stall_len > 0) ? stall_at % RD_LAT : 0);
            end
        end
        if (rst_at < 0) exp_q.push_back(e);
        req_i      = 1'b1;
        stall_i    = 1'b0;
        is_store_i = t.store;
        size_i     = t.size;
        sign_ext_i = t.sext;
        addr_i     = t.addr;
        wdata_i    = t.wdata;
        wreg_i     = t.wreg;
        waddr_i    = t.waddr;
        ds         = dstall;
        @(posedge clk); #1;
        for (int c = 0; c < 200; c++) begin
            garble();
            rst = (c == rst_at);
            if (done_o) begin
                if (ds > 0) begin
                    stall_i = 1'b1;
                    ds--;
                end else begin
                    stall_i = 1'b0;
                    req_i   = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
            end else begin
                stall_i = (c >= stall_at && c < stall_at + stall_len);
            end
            if (rst) begin
                @(posedge clk); #1;
                rst     = 1'b0;
                req_i   = 1'b0;
                stall_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL timeout: got no done_o expected done within 200 cycles");
        req_i   = 1'b0;
        stall_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        wr_q.delete();
    endtask

    function automatic txn_t mk(input logic st, input logic [1:0] sz,
                                input logic sx, input logic [31:0] a,
                                input logic [31:0] wd);
        txn_t t;
        t.store = st;
        t.size  = sz;
        t.sext  = sx;
        t.addr  = a;
        t.wdata = wd;
        t.wreg  = 1'($urandom_range(0, 1));
        t.waddr = 5'($urandom_range(0, 31));
        return t;
    endfunction

    initial begin
        txn_t t;
        clk = 1'b0;
        rst = 1'b1;
        stall_i = 1'b0;
        req_i = 1'b0;
        is_store_i = 1'b0;
        size_i = 2'd0;
        sign_ext_i = 1'b0;
        addr_i = '0;
        wdata_i = 32'd0;
        wreg_i = 1'b0;
        waddr_i = 5'd0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h100] = 8'h78;
        ram[12'h101] = 8'h56;
        ram[12'h102] = 8'h34;
        ram[12'h103] = 8'h12;
        ram[12'h003] = 8'h80;
        req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        req_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_re", 32'(mem_re_o), 32'd0);

        chk("ram_init", 32'(ram[12'h100]), 32'h78);
        run(mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0), -1, 0, 0, -1);
        run(mk(1'b0, 2'd0, 1'b1, 32'h3, 32'h0), -1, 0, 0, -1);
        run(mk(1'b0, 2'd0, 1'b0, 32'h3, 32'h0), -1, 0, 0, -1);
        run(mk(1'b1, 2'd1, 1'b0, 32'h20, 32'hAABBCCDD), -1, 0, 0, -1);
        run(mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0), RD_LAT + 1, 3, 0, -1);
        run(mk(1'b0, 2'd1, 1'b1, 32'h100, 32'h0), -1, 0, 2, -1);
        run(mk(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344), -1, 0, 0, 2);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_pending_wr", 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;
        run(mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0), -1, 0, 0, -1);
        run(mk(1'b1, 2'd3, 1'b0, 32'h50, 32'hFFFFFFFF), -1, 0, 0, -1);
        run(mk(1'b0, 2'd2, 1'b1, 32'hFFFFFFFE, 32'h0), -1, 0, 0, -1);
        run(mk(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF), -1, 0, 0, -1);
        run(mk(1'b1, 2'd2, 1'b0, 32'h1F0, 32'hCAFEF00D), 1, 2, 0, -1);

        for (int i = 0; i < 150; i++) begin
            t.store = 1'($urandom_range(0, 1));
            t.size  = 2'($urandom_range(0, 3));
            t.sext  = 1'($urandom_range(0, 1));
            t.addr  = ($urandom_range(0, 3) == 0) ?
                      32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            t.wdata = $urandom;
            t.wreg  = 1'($urandom_range(0, 1));
            t.waddr = 5'($urandom_range(0, 31));
            run(t, -1, 0, $urandom_range(0, 1), -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
